mc_controller: RTL and testbench

- Multicycle RV32I control unit; successor to the single-cycle controller.
- Sequences each instruction through a Moore FSM and drives datapath selects and enables for one shared memory port.
- Adds a memory ready handshake, full six-way branch evaluation, an optional handshake to an external M-extension unit, and an illegal-instruction trap.
- Sits between the instruction register and the multicycle datapath.

---
 rtl/mc_controller.sv | 160 ++++++++++++++++
 tb/tb_mc_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM that sequences fetch, decode and execute
// over one shared memory port, with an optional M-extension handshake and a sticky trap.
module mc_controller #(
  parameter int ALUCTRL_W  = 4,
  parameter bit ENABLE_M   = 1'b1,
  parameter bit BRANCH_ALL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 Ltu,
  input  logic                 mem_ready,
  input  logic                 mext_done,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [2:0]           ImmSrc,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 mext_start,
  output logic                 illegal
);
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R   = 7'b0110011,
                         OP_I    = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI  = 7'b0110111;
  localparam logic [6:0] F7_MEXT = 7'b0000001;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3, A_XOR = 4'd4,
                         A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_MEXT, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  state_t state_q, state_d;
  logic   mext_wait_q, mext_wait_d;
  logic   br_legal, br_cond;
  logic [3:0] exec_fn, alu4;

  always_comb begin
    br_legal = 1'b0;
    br_cond  = 1'b0;
    case (funct3)
      3'b000: begin br_legal = 1'b1;       br_cond = Zero;  end
      3'b001: begin br_legal = 1'b1;       br_cond = !Zero; end
      3'b100: begin br_legal = BRANCH_ALL; br_cond = Lt;    end
      3'b101: begin br_legal = BRANCH_ALL; br_cond = !Lt;   end
      3'b110: begin br_legal = BRANCH_ALL; br_cond = Ltu;   end
      3'b111: begin br_legal = BRANCH_ALL; br_cond = !Ltu;  end
      default: ;
    endcase
  end

  // Immediate forms never subtract; only funct3=101 uses funct7[5] for both forms.
  always_comb begin
    case (funct3)
      3'b000:  exec_fn = (state_q == S_EXECR && funct7[5]) ? A_SUB : A_ADD;
      3'b001:  exec_fn = A_SLL;
      3'b010:  exec_fn = A_SLT;
      3'b011:  exec_fn = A_SLTU;
      3'b100:  exec_fn = A_XOR;
      3'b101:  exec_fn = funct7[5] ? A_SRA : A_SRL;
      3'b110:  exec_fn = A_OR;
      default: exec_fn = A_AND;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mext_wait_d = (state_q == S_MEXT) && !mext_done;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R: begin
            if (funct7 == F7_MEXT) state_d = ENABLE_M ? S_MEXT : S_TRAP;
            else                   state_d = S_EXECR;
          end
          OP_I:    state_d = S_EXECI;
          OP_BR:   state_d = S_BRANCH;
          OP_JAL:  state_d = S_JAL;
          OP_LUI:  state_d = S_LUI;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
      S_MEXT:     if (mext_done) state_d = S_FETCH;
      S_BRANCH:   state_d = br_legal ? S_FETCH : S_TRAP;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      mext_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mext_wait_q <= mext_wait_d;
    end
  end

  // Everything is forced low while reset is held, including the FETCH defaults.
  always_comb begin
    mem_req = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; AdrSrc = 1'b0;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; ImmSrc = 3'b000;
    RegWrite = 1'b0; mext_start = 1'b0; illegal = 1'b0; alu4 = A_ADD;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
          IRWrite = mem_ready; PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01; ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10; ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
        end
        S_MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
        S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
        S_MEMWRITE: begin mem_req = 1'b1; MemWrite = 1'b1; AdrSrc = 1'b1; end
        S_EXECR:    begin ALUSrcA = 2'b10; alu4 = exec_fn; end
        S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu4 = exec_fn; end
        S_ALUWB:    RegWrite = 1'b1;
        S_MEXT: begin
          mext_start = !mext_wait_q;
          if (mext_done) begin RegWrite = 1'b1; ResultSrc = 2'b11; end
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10; ImmSrc = 3'b010; alu4 = A_SUB;
          PCWrite = br_legal && br_cond;
        end
        S_JAL:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
        S_LUI:  begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = 3'b100; end
        S_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign ALUControl = ALUCTRL_W'(alu4);
endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-instruction expectations from a reference
// model go to a scoreboard; a negedge monitor summarizes each instruction and compares.
module tb_mc_controller;
  localparam int K_LD = 0, K_ST = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_LUI = 6,
                 K_MX = 7, K_BAD = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic Zero, Lt, Ltu, mem_ready, mext_done;
  logic mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, mext_start, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  logic reset_b;
  logic [6:0] op_b, funct7_b;
  logic [2:0] funct3_b;
  logic Zero_b, mem_ready_b;
  logic mem_req_b, MemWrite_b, IRWrite_b, PCWrite_b, AdrSrc_b, RegWrite_b, mext_start_b, illegal_b;
  logic [1:0] ALUSrcA_b, ALUSrcB_b, ResultSrc_b;
  logic [2:0] ImmSrc_b;
  logic [3:0] ALUControl_b;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready), .mext_done(mext_done),
    .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .mext_start(mext_start), .illegal(illegal));

  mc_controller #(.ALUCTRL_W(4), .ENABLE_M(1'b0), .BRANCH_ALL(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_b), .op(op_b), .funct3(funct3_b), .funct7(funct7_b),
    .Zero(Zero_b), .Lt(1'b0), .Ltu(1'b0), .mem_ready(mem_ready_b), .mext_done(1'b0),
    .mem_req(mem_req_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b), .PCWrite(PCWrite_b),
    .AdrSrc(AdrSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ResultSrc(ResultSrc_b),
    .ImmSrc(ImmSrc_b), .RegWrite(RegWrite_b), .ALUControl(ALUControl_b),
    .mext_start(mext_start_b), .illegal(illegal_b));

  typedef struct packed {
    logic [7:0] len;
    logic [3:0] n_rw;
    logic [1:0] wb;
    logic [3:0] n_pcw;
    logic [3:0] n_irw;
    logic [3:0] n_ms;
    logic [7:0] n_mw;
    logic [7:0] n_mrq;
    logic [3:0] alu_pre;
    logic [3:0] alu_last;
    logic       trap;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur, mon_exp;
  bit   open = 1'b0, prev_fetch = 1'b0, fnow;
  int   total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7, input bit r);
    case (f3)
      3'd0: return (r && f7[5]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7[5] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // A FETCH cycle is the only one requesting memory at the PC address.
  always @(negedge clk) begin
    if (!reset_n) begin
      open = 1'b0;
      prev_fetch = 1'b0;
    end else begin
      fnow = mem_req && !AdrSrc;
      if (open && ((fnow && !prev_fetch) || illegal)) begin
        cur.trap = illegal;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected act=%h exp=none", cur);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cur !== mon_exp) begin
            bad++;
            $display("FAIL sb_instr act=%h exp=%h (len %0d vs %0d)", cur, mon_exp, cur.len, mon_exp.len);
          end
        end
        open = 1'b0;
      end
      if (!open && fnow && !illegal) begin
        open = 1'b1;
        cur = '0;
      end
      if (open) begin
        cur.len = cur.len + 8'd1;
        if (RegWrite) begin cur.n_rw = cur.n_rw + 4'd1; cur.wb = ResultSrc; end
        if (PCWrite)    cur.n_pcw = cur.n_pcw + 4'd1;
        if (IRWrite)    cur.n_irw = cur.n_irw + 4'd1;
        if (mext_start) cur.n_ms  = cur.n_ms + 4'd1;
        if (MemWrite)   cur.n_mw  = cur.n_mw + 8'd1;
        if (mem_req)    cur.n_mrq = cur.n_mrq + 8'd1;
        cur.alu_pre  = cur.alu_last;
        cur.alu_last = ALUControl;
      end
      prev_fetch = fnow;
    end
  end

  // Drives one instruction: fs fetch stalls, ms memory stalls, dd M-ext latency.
  // abort_k >= 0 pulls reset at that cycle instead of completing.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic [6:0] f7,
                           input int fs, input int ms, input int dd,
                           input logic z, input logic lt, input logic ltu, input int abort_k);
    rec_t e;
    int   len;
    logic [6:0] opc;
    e = '0;
    e.n_pcw = 4'd1; e.n_irw = 4'd1; e.n_mrq = 8'(fs + 1);
    case (kind)
      K_LD:  begin opc = 7'b0000011; len = fs + ms + 5; e.n_mrq = 8'(fs + ms + 2); e.n_rw = 4'd1; e.wb = 2'd1; end
      K_ST:  begin opc = 7'b0100011; len = fs + ms + 4; e.n_mrq = 8'(fs + ms + 2); e.n_mw = 8'(ms + 1); end
      K_R:   begin opc = 7'b0110011; len = fs + 4; e.n_rw = 4'd1; e.alu_pre = alu_ref(f3, f7, 1'b1); end
      K_I:   begin opc = 7'b0010011; len = fs + 4; e.n_rw = 4'd1; e.alu_pre = alu_ref(f3, f7, 1'b0); end
      K_BR:  begin opc = 7'b1100011; len = fs + 3; e.alu_last = 4'd1;
                   e.n_pcw = 4'(1 + int'(br_ref(f3, z, lt, ltu))); end
      K_JAL: begin opc = 7'b1101111; len = fs + 4; e.n_rw = 4'd1; e.n_pcw = 4'd2; end
      K_LUI: begin opc = 7'b0110111; len = fs + 4; e.n_rw = 4'd1; end
      K_MX:  begin opc = 7'b0110011; len = fs + dd + 3; e.n_rw = 4'd1; e.wb = 2'd3; e.n_ms = 4'd1; end
      default: begin opc = 7'b0000000; len = fs + 2; e.trap = 1'b1; end
    endcase
    e.len = 8'(len);
    if (abort_k < 0) exp_q.push_back(e);
    op = opc; funct3 = f3; funct7 = f7; Zero = z; Lt = lt; Ltu = ltu;
    for (int k = 0; k < len; k++) begin
      if (k == abort_k) begin
        chk("pre_reset_memwrite", {mem_req, MemWrite}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("async_reset_drop", {mem_req, MemWrite, AdrSrc}, 3'b000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("after_reset_fetch", {mem_req, AdrSrc, illegal}, 3'b100);
        return;
      end
      if (k <= fs) mem_ready = (k == fs);
      else if ((kind == K_LD || kind == K_ST) && k >= fs + 3 && k <= fs + 3 + ms)
        mem_ready = (k == fs + 3 + ms);
      else mem_ready = 1'($urandom);
      if (kind == K_MX && k >= fs + 2 && k <= fs + 2 + dd) mext_done = (k == fs + 2 + dd);
      else mext_done = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, fs, ms, dd;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] brf3 [6];
    brf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    reset_n = 1'b0; reset_b = 1'b0;
    op = '0; funct3 = '0; funct7 = '0; Zero = 0; Lt = 0; Ltu = 0; mem_ready = 1'b1; mext_done = 1'b1;
    op_b = '0; funct3_b = '0; funct7_b = '0; Zero_b = 0; mem_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enables", {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, mext_start, illegal}, 7'd0);
    chk("reset_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl}, 16'd0);
    reset_n = 1'b1;

    run_instr(K_LD,  3'b010, 7'h00, 0, 0, 0, 0, 0, 0, -1);  // lw, no stalls
    run_instr(K_R,   3'b000, 7'h00, 3, 0, 0, 0, 0, 0, -1);  // add after 3 fetch stalls
    run_instr(K_R,   3'b000, 7'h20, 0, 0, 0, 0, 0, 0, -1);  // sub
    run_instr(K_I,   3'b101, 7'h20, 1, 0, 0, 0, 0, 0, -1);  // srai
    run_instr(K_BR,  3'b101, 7'h00, 0, 0, 0, 0, 0, 0, -1);  // bge, Lt=0
    run_instr(K_BR,  3'b100, 7'h00, 0, 0, 0, 0, 0, 0, -1);  // blt, Lt=0
    run_instr(K_MX,  3'b000, 7'h01, 0, 0, 6, 0, 0, 0, -1);  // mul
    run_instr(K_MX,  3'b100, 7'h01, 2, 0, 0, 0, 0, 0, -1);  // done in first MEXT cycle
    run_instr(K_ST,  3'b010, 7'h00, 0, 2, 0, 0, 0, 0, -1);
    run_instr(K_JAL, 3'b000, 7'h00, 0, 0, 0, 0, 0, 0, -1);
    run_instr(K_LUI, 3'b011, 7'h00, 0, 0, 0, 0, 0, 0, -1);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 7);
      fs = $urandom_range(0, 3); ms = $urandom_range(0, 3); dd = $urandom_range(0, 7);
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      if (kind == K_R) f7 = ($urandom % 2) ? 7'h20 : 7'h00;
      if (kind == K_MX) f7 = 7'h01;
      if (kind == K_BR) f3 = brf3[$urandom_range(0, 5)];
      run_instr(kind, f3, f7, fs, ms, dd, 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    // Store held in MEMWRITE, reset pulled in its third MEMWRITE cycle.
    run_instr(K_ST, 3'b010, 7'h00, 0, 5, 0, 0, 0, 0, 5);
    run_instr(K_BAD, 3'b000, 7'h00, 1, 0, 0, 0, 0, 0, -1);
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'($urandom); mext_done = 1'($urandom);
      @(posedge clk); #1;
      chk("trap_sticky", {illegal, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, mext_start}, 7'b1000000);
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reduced configuration: blt and mul are illegal, beq is not.
    @(posedge clk); #1;
    reset_b = 1'b1; op_b = 7'b1100011; funct3_b = 3'b100; mem_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_blt_branch", {PCWrite_b, illegal_b}, 2'b00);
    @(posedge clk); #1;
    chk("b_blt_trap", illegal_b, 1'b1);
    for (int c = 0; c < 3; c++) begin
      mem_ready_b = 1'($urandom); op_b = 7'($urandom);
      @(posedge clk); #1;
      chk("b_trap_sticky", {illegal_b, mem_req_b, IRWrite_b, PCWrite_b}, 4'b1000);
    end
    reset_b = 1'b0;
    #1;
    chk("b_reset_clears", {illegal_b, mem_req_b}, 2'b00);
    @(posedge clk); #1;
    reset_b = 1'b1; op_b = 7'b0110011; funct7_b = 7'h01; funct3_b = 3'b000; mem_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_mul_trap", {illegal_b, mext_start_b, RegWrite_b}, 3'b100);
    reset_b = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1; op_b = 7'b1100011; funct3_b = 3'b000; funct7_b = 7'h00; Zero_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_beq_taken", {PCWrite_b, illegal_b, ALUControl_b}, 6'b10_0001);
    @(posedge clk); #1;
    chk("b_beq_refetch", {illegal_b, mem_req_b, AdrSrc_b}, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
